regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised successor to the processor's integer register file, sitting in the decode stage of the pipelined core. Provides NUM_RD asynchronous read ports and one synchronous write port, with a hardwired-zero register 0 and a reset-triggered clear sequencer. The sequencer zeroes every entry after reset and holds off the pipeline through a `ready` flag. Optional write-to-read bypass removes the write-back/decode hazard.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1, entry 0 always reads 0 and ignores writes
---
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `write_en`  in  1  write strobe, sampled at rising edge
- `WriteAdd`  in  ADDR_W  write address
- `Reg_WriteData`  in  DATA_W  write data
- `ReadAdd`  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- `ReadData`  out  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W]
- `ready`  out  1  high once clear sequence is complete
- `wr_drop`  out  1  registered; pulses 1 cycle when a write was discarded

## Operation
- FSM states: CLEAR, READY.
- Reset:
  - rst=1 at an edge → state CLEAR, `clr_idx`=0, `ready`=0, `wr_drop`=0.
  - rst held high keeps state CLEAR with `clr_idx`=0; no entry is written.
- CLEAR, each edge with rst=0:
  - entries[`clr_idx`] ← 0; `clr_idx` ← `clr_idx`+1.
  - When `clr_idx` = 2**ADDR_W−1, state → READY; `clr_idx` wraps to 0.
- CLEAR, external writes: `write_en`=1 is discarded and `wr_drop`=1 the next cycle.
- CLEAR, reads: `ReadData` is forced to 0 on all ports regardless of array contents.
- READY, writes: `write_en`=1 → entries[`WriteAdd`] ← `Reg_WriteData`.
- READY, writes to entry 0 with ZERO_REG=1: discarded; `wr_drop` is **not** asserted (architectural no-op).
- READY, reads: port i returns entries[`ReadAdd`[i]] combinationally.
- Reads of entry 0 with ZERO_REG=1 return 0 in every state.
- Multiple ports may read the same address; each returns identical data.
- rst asserted in READY (mid-operation): next state CLEAR, and the full clear sequence repeats. A write on that same edge is discarded; rst has priority.
- No state other than the array, FSM, `clr_idx` and `wr_drop` exists.

## Timing
- Read latency: 0 cycles (combinational from `ReadAdd` and array).
- Write latency: 1 cycle; data is visible to non-bypassed reads after the write edge.
- Clear duration: exactly 2**ADDR_W edges with rst=0. `ready` rises after the 2**ADDR_W-th edge (32 edges at defaults).
- Reset values of outputs:
  - `ready`=0
  - `wr_drop`=0
  - `ReadData`=0 (all ports, forced by CLEAR)
- `wr_drop` is high for exactly one cycle per discarded write.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - in READY with `write_en`=1, any read port whose address equals `WriteAdd` returns `Reg_WriteData` in the same cycle.
  - ZERO_REG=1 still returns 0 for address 0.
  - No bypass in CLEAR.
- Undefined: same-cycle reads return the pre-write array value; new data is visible from the next cycle.

## Test plan
- **Reset/clear:**
  - Stimulus: pulse rst for 1 cycle, then deassert.
  - Required: `ready`=0 for 32 cycles and 1 from cycle 33; all 32 entries read 0.
- **Write/read:**
  - Stimulus: in READY, write 0xDEADBEEF to entry 5; next cycle read port0=5, port1=5.
  - Required: both ports = 0xDEADBEEF.
- **Zero register:**
  - Stimulus: write 0x12345678 to entry 0.
  - Required: reads of entry 0 return 0; `wr_drop` stays 0.
- **Write during CLEAR:**
  - Stimulus: `write_en`=1, entry 7, data 0xA5A5A5A5 at clear cycle 3.
  - Required: `wr_drop`=1 for one cycle; entry 7 reads 0 after `ready`.
- **Bypass:**
  - Stimulus: in READY, write 0xCAFEF00D to entry 9 while port1 reads 9 in the same cycle.
  - Required with `REGFILE_BYPASS_EN`: 0xCAFEF00D that cycle.
  - Required without it: old value that cycle, 0xCAFEF00D next cycle.
- **Reset mid-operation:**
  - Stimulus: fill entries 1..31 with index values; assert rst in READY together with a write.
  - Required: write discarded, `ready`=0, and after 32 cycles all entries read 0.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-port integer register file: NUM_RD combinational read ports, one write port,
// optional hardwired zero entry and a post-reset clear sequencer. Optional bypass: REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        WriteAdd,
  input  logic [DATA_W-1:0]        Reg_WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] ReadAdd,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   entries [DEPTH];

  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_data;
  logic                wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (WriteAdd == '0);

  // The clear sequencer owns the array port while in CLEAR; reset blocks all writes.
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = WriteAdd;
    arr_data = Reg_WriteData;
    if (!rst) begin
      if (state == CLEAR) begin
        arr_we   = 1'b1;
        arr_addr = clr_idx;
        arr_data = '0;
      end else if (write_en && !wr_zero) begin
        arr_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      entries[arr_addr] <= arr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          wr_drop <= write_en;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == {ADDR_W{1'b1}}) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: begin
          wr_drop <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = ReadAdd[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = entries[ra];
        if (state == CLEAR || ((ZERO_REG != 0) && ra == '0)) begin
          rd = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_en && WriteAdd == ra) begin
          rd = Reg_WriteData;
        end
`endif
      end

      assign ReadData[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: stimulus pushes expected outputs from an
// abstract model, a negedge monitor pops and compares them.
module tb_regfile_multiport;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     write_en;
  logic [ADDR_W-1:0]        WriteAdd;
  logic [DATA_W-1:0]        Reg_WriteData;
  logic [NUM_RD*ADDR_W-1:0] ReadAdd;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic                     ready;
  logic                     wr_drop;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .WriteAdd(WriteAdd),
    .Reg_WriteData(Reg_WriteData), .ReadAdd(ReadAdd), .ReadData(ReadData),
    .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic              ready;
    logic              wr_drop;
    logic [DATA_W-1:0] rd [NUM_RD];
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Reference model: memory contents plus number of clear edges still owed.
  logic [DATA_W-1:0] mem [DEPTH];
  int                clear_left;
  bit                drop;
  bit                model_valid = 0;

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (clear_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write_en && WriteAdd == a) return Reg_WriteData;
`endif
    return mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      clear_left = DEPTH;
      drop = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else if (clear_left > 0) begin
      drop = write_en;
      clear_left--;
    end else begin
      drop = 0;
      if (write_en && WriteAdd != 0) mem[WriteAdd] = Reg_WriteData;
    end
    model_valid = 1;
  endtask

  task automatic cyc(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                     input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra0,
                     input logic [ADDR_W-1:0] ra1);
    exp_t e;
    rst = r; write_en = we; WriteAdd = wa; Reg_WriteData = wd;
    ReadAdd = {ra1, ra0};
    if (model_valid) begin
      e.cyc     = cycle;
      e.ready   = (clear_left == 0);
      e.wr_drop = drop;
      e.rd[0]   = model_read(ra0);
      e.rd[1]   = model_read(ra1);
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
  endtask

  task automatic check(input string name, input int c, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ready", e.cyc, {31'b0, ready}, {31'b0, e.ready});
      check("wr_drop", e.cyc, {31'b0, wr_drop}, {31'b0, e.wr_drop});
      check("rd0", e.cyc, ReadData[0 +: DATA_W], e.rd[0]);
      check("rd1", e.cyc, ReadData[DATA_W +: DATA_W], e.rd[1]);
      $display("[TB] cyc %0d ready=%0d wr_drop=%0d rd0=%h rd1=%h", e.cyc, ready, wr_drop,
               ReadData[0 +: DATA_W], ReadData[DATA_W +: DATA_W]);
    end
  end

  task automatic read_all();
    for (int i = 0; i < DEPTH; i += 2) cyc(0, 0, 0, 0, ADDR_W'(i), ADDR_W'(i + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; write_en = 0; WriteAdd = 0; Reg_WriteData = 0; ReadAdd = 0;
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'h1111_2222, 3, 5);

    // Clear sequence, with a write landing on clear cycle 3.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) cyc(0, 1, 7, 32'hA5A5_A5A5, 7, 2);
      else        cyc(0, 0, 0, 0, ADDR_W'($urandom), 7);
    end
    read_all();

    cyc(0, 1, 5, 32'hDEAD_BEEF, 1, 2);
    cyc(0, 0, 0, 0, 5, 5);
    cyc(0, 1, 0, 32'h1234_5678, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 9, 32'hCAFE_F00D, 3, 9);
    cyc(0, 0, 0, 0, 9, 9);

    // Fill, then reset in READY together with a write.
    for (int i = 1; i < DEPTH; i++) cyc(0, 1, ADDR_W'(i), DATA_W'(i), ADDR_W'(i), ADDR_W'(i - 1));
    read_all();
    cyc(1, 1, 4, 32'hFFFF_FFFF, 4, 31);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 4, ADDR_W'(i));
    read_all();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) == 0), $urandom_range(1), ADDR_W'($urandom), $urandom,
          ADDR_W'($urandom), ADDR_W'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
